// File: rtl/pc_sequencer.sv
// Run-control sequencer for a CGRA tile program counter.
// Steps the external PC through [start_addr..end_addr] a configurable number of
// times. It drives the PC's load/incr/clken strobes and flags the cycles in which
// pc_count points at an instruction to execute.
module pc_sequencer #(
  parameter int C_WIDTH      = 4,
  parameter int C_LOOP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    stall,
  input  logic [C_WIDTH-1:0]      start_addr,
  input  logic [C_WIDTH-1:0]      end_addr,
  input  logic [C_LOOP_WIDTH-1:0] loop_count,
  input  logic [C_WIDTH-1:0]      pc_count,
  output logic                    pc_clken,
  output logic                    pc_load,
  output logic                    pc_incr,
  output logic [C_WIDTH-1:0]      pc_load_value,
  output logic                    instr_valid,
  output logic                    busy,
  output logic                    done,
  output logic [C_LOOP_WIDTH-1:0] iter_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [C_WIDTH-1:0]      start_addr_q, start_addr_d;
  logic [C_WIDTH-1:0]      end_addr_q, end_addr_d;
  logic [C_LOOP_WIDTH-1:0] iters_left_q, iters_left_d;
  logic [C_LOOP_WIDTH-1:0] iter_done_q, iter_done_d;

  logic at_end;
  assign at_end = (pc_count == end_addr_q);

  // Next-state logic: launch in IDLE, walk the window in RUN, and let abort override everything.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    iters_left_d = iters_left_q;
    iter_done_d  = iter_done_q;
    if (abort) begin
      // Abort keeps the captured window and the completed-iteration count.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_addr_d = start_addr;
            end_addr_d   = end_addr;
            iters_left_d = (loop_count == '0) ? C_LOOP_WIDTH'(1) : loop_count;
            iter_done_d  = '0;
            state_d      = S_LOAD;
          end
        end
        S_LOAD: state_d = S_RUN;
        S_RUN: begin
          if (!stall && at_end) begin
            iter_done_d = iter_done_q + 1'b1;
            if (iters_left_q > C_LOOP_WIDTH'(1)) begin
              iters_left_d = iters_left_q - 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state, captured window, pc_count and stall.
  always_comb begin
    pc_clken    = 1'b0;
    pc_load     = 1'b0;
    pc_incr     = 1'b0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy     = 1'b1;
        pc_clken = 1'b1;
        pc_load  = 1'b1;
      end
      S_RUN: begin
        busy = 1'b1;
        if (!stall) begin
          instr_valid = 1'b1;
          pc_clken    = 1'b1;
          if (!at_end) begin
            pc_incr = 1'b1;
          end else if (iters_left_q > C_LOOP_WIDTH'(1)) begin
            pc_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_load_value = start_addr_q;
  assign iter_done     = iter_done_q;

  // State and capture registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      iters_left_q <= '0;
      iter_done_q  <= '0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      iters_left_q <= iters_left_d;
      iter_done_q  <= iter_done_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. A behavioural PC register closes the
// loop, and a table of launch configurations sets the expected valid count,
// done timing, iteration count and strobe counts for each run.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, stall;
  logic [3:0] start_addr, end_addr, pc_count;
  logic [7:0] loop_count;
  logic       pc_clken, pc_load, pc_incr, instr_valid, busy, done;
  logic [3:0] pc_load_value;
  logic [7:0] iter_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.C_WIDTH(4), .C_LOOP_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .start_addr(start_addr), .end_addr(end_addr), .loop_count(loop_count),
    .pc_count(pc_count), .pc_clken(pc_clken), .pc_load(pc_load), .pc_incr(pc_incr),
    .pc_load_value(pc_load_value), .instr_valid(instr_valid), .busy(busy),
    .done(done), .iter_done(iter_done)
  );

  // External program counter driven by the sequencer's strobes.
  logic [3:0] pc_model = 4'd0;
  always @(posedge clk) begin
    if (pc_clken) begin
      if (pc_load) pc_model <= pc_load_value;
      else if (pc_incr) pc_model <= pc_model + 4'd1;
    end
  end
  assign pc_count = pc_model;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [3:0] sa;
    logic [3:0] ea;
    logic [7:0] lc;
    logic [3:0] stall_pc;
    int         stall_len;
    int         exp_valid;
    int         exp_done_k;
    int         exp_iter;
    int         exp_loads;
  } vec_t;

  vec_t vecs[6];

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".strobes"}, {pc_clken, pc_load, pc_incr, instr_valid}, 0);
    check({tag, ".pc_load_value"}, pc_load_value, 0);
    check({tag, ".iter_done"}, iter_done, 0);
  endtask

  // Launch one configuration and follow it cycle by cycle until done or the budget expires.
  task automatic run_vec(input int i, input bit hold_start);
    vec_t       v;
    logic [3:0] exp_pc;
    int k, n_valid, n_loads, overlap, pc_err, done_k, stall_rem, load_k1;
    v = vecs[i];
    exp_pc = v.sa;
    n_valid = 0; n_loads = 0; overlap = 0; pc_err = 0; done_k = -1; load_k1 = 0;
    stall_rem = v.stall_len;
    @(negedge clk);
    start_addr = v.sa; end_addr = v.ea; loop_count = v.lc; start = 1'b1;
    @(posedge clk);  // accepting edge T0
    #1 start = hold_start;
    for (k = 1; k <= 200; k++) begin
      stall = (k >= 2 && stall_rem > 0 && pc_count == v.stall_pc);
      if (stall) stall_rem--;
      @(negedge clk);
      if (k == 1) load_k1 = pc_load;
      if (pc_load && pc_incr) overlap++;
      if (pc_load) n_loads++;
      if (instr_valid) begin
        n_valid++;
        if (pc_count !== exp_pc) pc_err++;
        exp_pc = (exp_pc == v.ea) ? v.sa : exp_pc + 4'd1;
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    check($sformatf("v%0d.load_at_T0+1", i), load_k1, 1);
    check($sformatf("v%0d.valid_count", i), n_valid, v.exp_valid);
    check($sformatf("v%0d.pc_sequence_errors", i), pc_err, 0);
    check($sformatf("v%0d.done_cycle", i), done_k, v.exp_done_k);
    check($sformatf("v%0d.iter_done", i), iter_done, v.exp_iter);
    check($sformatf("v%0d.load_strobes", i), n_loads, v.exp_loads);
    check($sformatf("v%0d.load_incr_overlap", i), overlap, 0);
    if (hold_start) begin
      // DONE ignores start; the following IDLE cycle accepts it, so LOAD comes one cycle later.
      @(negedge clk);
      check($sformatf("v%0d.hold.idle_busy", i), busy, 0);
      check($sformatf("v%0d.hold.iter_done_kept", i), iter_done, v.exp_iter);
      @(negedge clk);
      check($sformatf("v%0d.hold.relaunch_load", i), pc_load, 1);
      check($sformatf("v%0d.hold.relaunch_busy", i), busy, 1);
      start = 1'b0;
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
    @(negedge clk);
    check($sformatf("v%0d.idle_after", i), busy, 0);
  endtask

  initial begin
    vecs[0] = '{sa:4'd2,  ea:4'd5,  lc:8'd1, stall_pc:4'd0, stall_len:0, exp_valid:4,  exp_done_k:6,  exp_iter:1, exp_loads:1};
    vecs[1] = '{sa:4'd0,  ea:4'd1,  lc:8'd3, stall_pc:4'd0, stall_len:0, exp_valid:6,  exp_done_k:8,  exp_iter:3, exp_loads:3};
    vecs[2] = '{sa:4'd14, ea:4'd1,  lc:8'd0, stall_pc:4'd0, stall_len:0, exp_valid:4,  exp_done_k:6,  exp_iter:1, exp_loads:1};
    vecs[3] = '{sa:4'd2,  ea:4'd5,  lc:8'd1, stall_pc:4'd3, stall_len:2, exp_valid:4,  exp_done_k:8,  exp_iter:1, exp_loads:1};
    vecs[4] = '{sa:4'd7,  ea:4'd7,  lc:8'd4, stall_pc:4'd0, stall_len:0, exp_valid:4,  exp_done_k:6,  exp_iter:4, exp_loads:4};
    vecs[5] = '{sa:4'd0,  ea:4'd15, lc:8'd2, stall_pc:4'd0, stall_len:0, exp_valid:32, exp_done_k:34, exp_iter:2, exp_loads:2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    start_addr = 4'd9; end_addr = 4'd12; loop_count = 8'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, 1'b0);

    // Abort on the second visit to pc=4 of a three-iteration 2..5 loop.
    begin
      int seen4, found, done_seen;
      seen4 = 0; found = 0; done_seen = 0;
      @(negedge clk);
      start_addr = 4'd2; end_addr = 4'd5; loop_count = 8'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if (instr_valid && pc_count == 4'd4) begin
          seen4++;
          if (seen4 == 2) begin
            abort = 1'b1;
            found = 1;
          end
        end
      end
      check("abort.reached_pc4_twice", found, 1);
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("abort.busy", busy, 0);
      check("abort.iter_done_kept", iter_done, 1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      check("abort.no_done", done_seen, 0);
    end

    // One-edge reset clears everything, then a normal run follows.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset2");
    run_vec(0, 1'b0);

    // Start held high through a whole run.
    run_vec(1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
